// File: rtl/data_in.sv
// Input deserializer: packs four 64-bit IO beats (MSB beat first) into a 255-bit operand for the EC core.
// Optional framing check on beat 0, bit 63 is built when DATAIN_FRAME_CHECK_EN is defined.
module data_in #(
    parameter int unsigned WORDS_PER_JOB = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    input  logic [63:0]  i_in_data,
    output logic         o_in_ready,
    output logic         o_core_valid,
    output logic [254:0] o_core_data,
    output logic [1:0]   o_core_idx,
    output logic         o_core_last,
    input  logic         i_core_ready,
    output logic         o_err
);

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_JOB - 1);

    logic [255:0] asm_q, asm_d;
    logic [1:0]   bcnt_q, bcnt_d;
    logic         asm_full_q, asm_full_d;
    logic [254:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [1:0]   out_idx_q, out_idx_d;
    logic [1:0]   wcnt_q, wcnt_d;

    logic         in_fire;
    logic         core_fire;
    logic         slot_free;
    logic         load;
    logic [255:0] word;

    assign o_in_ready = !asm_full_q && !i_rst;

    always_comb begin
        in_fire     = i_in_valid && o_in_ready;
        core_fire   = out_valid_q && i_core_ready;
        slot_free   = !out_valid_q || core_fire;
        word        = {asm_q[255:64], i_in_data};
        load        = 1'b0;
        asm_d       = asm_q;
        bcnt_d      = bcnt_q;
        asm_full_d  = asm_full_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        wcnt_d      = wcnt_q;

        if (in_fire) begin
            bcnt_d = bcnt_q + 2'd1;
            case (bcnt_q)
                2'd0: asm_d[255:192] = i_in_data;
                2'd1: asm_d[191:128] = i_in_data;
                2'd2: asm_d[127:64]  = i_in_data;
                default: begin
                    // Final beat bypasses asm when the output slot frees this cycle.
                    if (slot_free) begin
                        out_d = word[254:0];
                        load  = 1'b1;
                    end else begin
                        asm_d      = word;
                        asm_full_d = 1'b1;
                    end
                end
            endcase
        end

        // asm_full blocks in_fire, so drain and direct load never coincide.
        if (asm_full_q && slot_free) begin
            out_d      = asm_q[254:0];
            asm_full_d = 1'b0;
            load       = 1'b1;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = wcnt_q;
            wcnt_d      = (wcnt_q == LAST_IDX) ? 2'd0 : wcnt_q + 2'd1;
        end else if (core_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            asm_q       <= '0;
            bcnt_q      <= '0;
            asm_full_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            wcnt_q      <= '0;
        end else begin
            asm_q       <= asm_d;
            bcnt_q      <= bcnt_d;
            asm_full_q  <= asm_full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign o_core_valid = out_valid_q;
    assign o_core_data  = out_q;
    assign o_core_idx   = out_idx_q;
    assign o_core_last  = (out_idx_q == LAST_IDX);

`ifdef DATAIN_FRAME_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (in_fire && (bcnt_q == 2'd0) && i_in_data[63]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_in.sv
// Directed + randomized bench for data_in, checked against a beat-list/word-queue reference model.
module tb_data_in;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         core_ready;

    logic         in_ready, core_valid, core_last, err;
    logic [254:0] core_data;
    logic [1:0]   core_idx;
    logic         in_ready1, core_valid1, core_last1, err1;
    logic [254:0] core_data1;
    logic [1:0]   core_idx1;

    always #5 clk = ~clk;

    data_in #(.WORDS_PER_JOB(3)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(in_ready), .o_core_valid(core_valid), .o_core_data(core_data),
        .o_core_idx(core_idx), .o_core_last(core_last), .i_core_ready(core_ready),
        .o_err(err)
    );

    data_in #(.WORDS_PER_JOB(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(in_ready1), .o_core_valid(core_valid1), .o_core_data(core_data1),
        .o_core_idx(core_idx1), .o_core_last(core_last1), .i_core_ready(core_ready),
        .o_err(err1)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: beats of the current word, queue of complete operands awaiting the core.
    logic [63:0]  beats[$];
    logic [254:0] exp_data[$];
    int           exp_idx[$];
    int           wcnt = 0;
    logic         err_exp = 1'b0;
    logic         dut_fire;

`ifdef DATAIN_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        beats.delete();
        exp_data.delete();
        exp_idx.delete();
        wcnt = 0;
        err_exp = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, steps one cycle.
    task automatic tick();
        logic       m_ready, m_in_fire, m_core_fire;
        logic [255:0] w;
        #1;
        m_ready     = !rst && (exp_data.size() < 2);
        m_in_fire   = in_valid && m_ready;
        m_core_fire = (exp_data.size() > 0) && core_ready;
        dut_fire    = in_valid && in_ready;

        chk("in_ready", in_ready, m_ready);
        chk("core_valid", core_valid, exp_data.size() > 0);
        chk("err", err, err_exp);
        chk("w1_in_ready", in_ready1, m_ready);
        chk("w1_valid", core_valid1, exp_data.size() > 0);
        chk("w1_err", err1, err_exp);
        if (exp_data.size() > 0) begin
            chk("core_data", core_data, exp_data[0]);
            chk("core_idx", core_idx, exp_idx[0]);
            chk("core_last", core_last, exp_idx[0] == 2);
            chk("w1_data", core_data1, exp_data[0]);
            chk("w1_idx", core_idx1, 0);
            chk("w1_last", core_last1, 1);
        end

        if (rst) begin
            model_reset();
        end else begin
            if (m_core_fire) begin
                void'(exp_data.pop_front());
                void'(exp_idx.pop_front());
            end
            if (m_in_fire) begin
                if (FRAME_CHECK && beats.size() == 0 && in_data[63]) err_exp = 1'b1;
                beats.push_back(in_data);
                if (beats.size() == 4) begin
                    w = {beats[0], beats[1], beats[2], beats[3]};
                    exp_data.push_back(w[254:0]);
                    exp_idx.push_back(wcnt);
                    wcnt = (wcnt + 1) % 3;
                    beats.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic [63:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            tick();
            n++;
        end while (!dut_fire && n < 100);
        chk("beat_accept", dut_fire, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] w0;
        logic [63:0]  ones;
        int sent, cyc;
        logic pending;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        core_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        tick();
        chk("rst_valid", core_valid, 0);
        chk("rst_data", core_data, 0);
        chk("rst_idx", core_idx, 0);
        chk("rst_last", core_last, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;

        // Streaming job with the core always ready.
        core_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            beat(64'(i));
            if (i == 4) begin
                w0 = {64'h1, 64'h2, 64'h3, 64'h4};
                chk("op0_value", core_data, w0[254:0]);
                chk("op0_valid", core_valid, 1);
            end
        end
        repeat (3) tick();

        // Core stalled: two words buffer, then drain in order.
        core_ready = 1'b0;
        for (int i = 1; i <= 8; i++) beat(64'(i + 100));
        in_valid = 1'b1;
        in_data  = 64'd109;
        repeat (3) tick();
        chk("stall_ready_low", in_ready, 0);
        core_ready = 1'b1;
        for (int i = 9; i <= 12; i++) beat(64'(i + 100));
        repeat (4) tick();

        // Random valid, toggling ready: 20 jobs of 3 words.
        sent = 0;
        cyc = 0;
        dut_fire = 1'b0;
        while (sent < 240 && cyc < 4000) begin
            core_ready = ~core_ready;
            pending = in_valid && !dut_fire;
            if (!pending) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom};
            end
            tick();
            if (dut_fire) sent++;
            cyc++;
        end
        chk("rand_beats", sent, 240);
        in_valid = 1'b0;
        core_ready = 1'b1;
        repeat (4) tick();

        // Reset mid-job: one word plus two beats in flight.
        core_ready = 1'b0;
        for (int i = 0; i < 6; i++) beat(64'(i + 500));
        do_reset();
        core_ready = 1'b1;
        ones = '1;
        for (int i = 0; i < 4; i++) beat(ones);
        chk("post_rst_idx", core_idx, 0);
        chk("post_rst_data", core_data, {255{1'b1}});
        repeat (2) tick();

        // Framing: MSB set on beat 0.
        do_reset();
        beat(64'h8000_0000_0000_0000);
        beat(64'h1);
        beat(64'h2);
        beat(64'h3);
        chk("frame_top", core_data[254:192], 0);
        chk("frame_err", err, FRAME_CHECK);
        repeat (3) tick();
        chk("frame_err_sticky", err, FRAME_CHECK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
